// File: rtl/signed_sat_accumulator_pkg.sv
// Shared types and saturation bounds for the signed saturating accumulator.
package sat_pkg;

    // Accumulating samples, or holding a finished burst result for the consumer.
    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } state_t;

    // Largest positive two's complement value representable in w bits.
    function automatic logic signed [31:0] sat_max(input int w);
        return (32'sd1 <<< (w - 1)) - 32'sd1;
    endfunction

    // Most negative two's complement value representable in w bits.
    function automatic logic signed [31:0] sat_min(input int w);
        return -(32'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/signed_sat_accumulator_sat_add_w.sv
// Combinational signed adder that clamps to the W-bit range instead of wrapping.
module sat_add_w
    import sat_pkg::*;
#(
    parameter int W = 8
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum,
    output logic                overflow
);

    localparam logic signed [W-1:0] MAXV = W'(sat_max(W));
    localparam logic signed [W-1:0] MINV = W'(sat_min(W));

    logic signed [W-1:0] raw;

    // Overflow only when both operands share a sign that the wrapped sum lost.
    always_comb begin
        raw      = a + b;
        overflow = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
        sum      = raw;
        if (overflow) begin
            sum = a[W-1] ? MINV : MAXV;
        end
    end

endmodule

// File: rtl/signed_sat_accumulator.sv
// Burst accumulator: sums LEN signed samples with per-step saturation and
// hands each burst total downstream on a valid/ready port with a sticky
// saturation flag.
module signed_sat_accumulator
    import sat_pkg::*;
#(
    parameter int IN_W  = 4,
    parameter int ACC_W = 8,
    parameter int LEN   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    up_valid,
    output logic                    up_ready,
    input  logic signed [IN_W-1:0]  up_data,
    output logic                    down_valid,
    input  logic                    down_ready,
    output logic signed [ACC_W-1:0] down_data,
    output logic                    down_sat
);

    localparam int              CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    sat_q, sat_d;
    logic signed [ACC_W-1:0] ddata_q, ddata_d;
    logic                    dsat_q, dsat_d;

    logic signed [ACC_W-1:0] sample_ext;
    logic signed [ACC_W-1:0] step_sum;
    logic                    step_ovf;
    logic                    accept;

    assign sample_ext = ACC_W'(up_data);

    // acc is always zero while a result is pending, so the same adder also
    // produces the first sample of the next burst in the OUT state.
    sat_add_w #(
        .W(ACC_W)
    ) u_add (
        .a       (acc_q),
        .b       (sample_ext),
        .sum     (step_sum),
        .overflow(step_ovf)
    );

    assign up_ready   = !flush && ((state_q == ACC) || down_ready);
    assign accept     = up_valid && up_ready;
    assign down_valid = (state_q == OUT);
    assign down_data  = ddata_q;
    assign down_sat   = dsat_q;

    // Next-state: accumulate, close a burst, release a result, or abort on flush.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        ddata_d = ddata_q;
        dsat_d  = dsat_q;

        case (state_q)
            ACC: begin
                if (accept) begin
                    if (cnt_q == LAST) begin
                        ddata_d = step_sum;
                        dsat_d  = sat_q | step_ovf;
                        acc_d   = '0;
                        cnt_d   = '0;
                        sat_d   = 1'b0;
                        state_d = OUT;
                    end else begin
                        acc_d = step_sum;
                        cnt_d = cnt_q + CNT_W'(1);
                        sat_d = sat_q | step_ovf;
                    end
                end
            end
            OUT: begin
                if (down_ready) begin
                    state_d = ACC;
                end
                if (accept) begin
                    acc_d = step_sum;
                    cnt_d = CNT_W'(1);
                    sat_d = step_ovf;
                end
            end
            default: state_d = ACC;
        endcase

        // A flush never accepts a sample, so it only has to clear the partial burst.
        if (flush) begin
            acc_d = '0;
            cnt_d = '0;
            sat_d = 1'b0;
        end
    end

    // State and datapath registers; reset drops any partial burst and pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            ddata_q <= '0;
            dsat_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            ddata_q <= ddata_d;
            dsat_q  <= dsat_d;
        end
    end

endmodule

// File: tb/tb_signed_sat_accumulator.sv
// Scoreboard bench for signed_sat_accumulator with a 5-bit accumulator so
// that saturation is exercised often.
module tb_signed_sat_accumulator;

    localparam int IN_W  = 4;
    localparam int ACC_W = 5;
    localparam int LEN   = 4;
    localparam int MAXV  = (1 << (ACC_W - 1)) - 1;
    localparam int MINV  = -(1 << (ACC_W - 1));

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    flush = 1'b0;
    logic                    up_valid = 1'b0;
    logic                    up_ready;
    logic signed [IN_W-1:0]  up_data = '0;
    logic                    down_valid;
    logic                    down_ready = 1'b0;
    logic signed [ACC_W-1:0] down_data;
    logic                    down_sat;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int data;
        bit sat;
    } result_t;

    result_t exp_q[$];

    // Reference model: the burst in progress and whether a result is outstanding.
    int m_acc = 0;
    int m_cnt = 0;
    bit m_sat = 0;
    bit m_pending = 0;

    signed_sat_accumulator #(
        .IN_W (IN_W),
        .ACC_W(ACC_W),
        .LEN  (LEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .up_valid  (up_valid),
        .up_ready  (up_ready),
        .up_data   (up_data),
        .down_valid(down_valid),
        .down_ready(down_ready),
        .down_data (down_data),
        .down_sat  (down_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_acc = 0;
        m_cnt = 0;
        m_sat = 0;
    endtask

    // One clock cycle of stimulus; the model follows the rules of the block.
    task automatic cycle(input bit uv, input int ud, input bit fl, input bit dr);
        bit exp_ready;
        @(negedge clk);
        up_valid   = uv;
        up_data    = ud[IN_W-1:0];
        flush      = fl;
        down_ready = dr;
        #1;
        exp_ready = !fl && (!m_pending || dr);
        chk("up_ready", int'(up_ready), int'(exp_ready));
        chk("down_valid", int'(down_valid), int'(m_pending));
        @(posedge clk);
        if (m_pending && dr) m_pending = 0;
        if (fl) begin
            model_clear();
        end else if (uv && exp_ready) begin
            m_acc = m_acc + ud;
            if (m_acc > MAXV) begin
                m_acc = MAXV;
                m_sat = 1;
            end else if (m_acc < MINV) begin
                m_acc = MINV;
                m_sat = 1;
            end
            m_cnt++;
            if (m_cnt == LEN) begin
                exp_q.push_back('{data: m_acc, sat: m_sat});
                m_pending = 1;
                model_clear();
            end
        end
    endtask

    task automatic burst(input int s0, input int s1, input int s2, input int s3);
        cycle(1, s0, 0, 1);
        cycle(1, s1, 0, 1);
        cycle(1, s2, 0, 1);
        cycle(1, s3, 0, 1);
    endtask

    // Monitor: every presented result must match the oldest expected one.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && down_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %0d, expected none at %0t", down_data, $time);
                end else begin
                    chk("down_data", int'(down_data), exp_q[0].data);
                    chk("down_sat", int'(down_sat), int'(exp_q[0].sat));
                    if (down_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        // Reset state
        #12;
        chk("rst_down_valid", int'(down_valid), 0);
        chk("rst_down_data", int'(down_data), 0);
        chk("rst_down_sat", int'(down_sat), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_up_ready", int'(up_ready), 1);

        // Plain sum and single-cycle valid
        burst(1, 2, 3, -1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);

        // Saturation at both bounds and recovery with sticky flag
        burst(7, 7, 7, 7);
        cycle(0, 0, 0, 1);
        burst(-8, -8, -8, -8);
        cycle(0, 0, 0, 1);
        burst(7, 7, 7, -8);
        cycle(0, 0, 0, 1);

        // Backpressure, then release together with the first sample of a new burst
        burst(2, 2, 2, 2);
        for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0);
        cycle(1, 3, 0, 1);
        cycle(1, 1, 0, 1);
        cycle(1, 1, 0, 1);
        cycle(1, 1, 0, 1);
        cycle(0, 0, 0, 1);

        // Flush discards the partial burst and the sample offered alongside it
        cycle(1, 5, 0, 1);
        cycle(1, 5, 0, 1);
        cycle(1, 4, 1, 1);
        burst(1, 1, 1, 1);
        cycle(0, 0, 0, 1);

        // Asynchronous reset while a result is pending
        burst(3, 3, 3, 3);
        cycle(0, 0, 0, 0);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_down_valid", int'(down_valid), 0);
        chk("arst_down_data", int'(down_data), 0);
        chk("arst_down_sat", int'(down_sat), 0);
        exp_q.delete();
        m_pending = 0;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        burst(1, 2, 3, -1);
        cycle(0, 0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)) - 8,
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7));
        end
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);

        chk("results_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
